// File: rtl/decode_stage.sv
// RV32I decode stage: single-entry pipeline register between fetch and execute.
// Splits the fetched word into the registered decode bus and holds it across stalls.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [15:0] full_op_code,
    output logic [1:0]  rd_data_sel,
    output logic [4:0]  rs1_sel,
    output logic [4:0]  rs2_sel,
    output logic [4:0]  rd_sel,
    output logic [31:0] imm,
    output logic        illegal
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned FOP_W = 16;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [FOP_W-1:0] full_op_code;
        logic [1:0]       rd_data_sel;
        logic [REG_W-1:0] rs1_sel;
        logic [REG_W-1:0] rs2_sel;
        logic [REG_W-1:0] rd_sel;
        logic [XLEN-1:0]  imm;
        logic             illegal;
    } dec_t;

    dec_t            dec_c;
    dec_t            bus_q;
    logic            accept_c;
    logic            b30_c;
    logic            b25_c;
    logic [6:0]      opc_c;
    logic [2:0]      f3_c;
    logic [XLEN-1:0] imm_i_c;
    logic [XLEN-1:0] imm_s_c;
    logic [XLEN-1:0] imm_b_c;
    logic [XLEN-1:0] imm_u_c;
    logic [XLEN-1:0] imm_j_c;

    assign opc_c   = instr_in[6:0];
    assign f3_c    = instr_in[14:12];
    assign imm_i_c = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s_c = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b_c = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u_c = {instr_in[31:12], 12'b0};
    assign imm_j_c = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};

    assign in_ready = !rst && !flush && (!out_valid || out_ready);
    assign accept_c = in_valid && in_ready;

    // Combinational decode of the offered word; illegal opcodes zero every derived field.
    always_comb begin
        dec_c         = '0;
        b30_c         = 1'b0;
        b25_c         = 1'b0;
        dec_c.rd_sel  = instr_in[11:7];
        dec_c.rs1_sel = instr_in[19:15];
        unique case (opc_c)
            OPC_LUI: begin
                dec_c.rs1_sel     = '0;
                dec_c.imm         = imm_u_c;
                dec_c.rd_data_sel = 2'b11;
            end
            OPC_AUIPC: begin
                dec_c.rs1_sel = '0;
                dec_c.imm     = imm_u_c;
            end
            OPC_JAL: begin
                dec_c.rs1_sel     = '0;
                dec_c.imm         = imm_j_c;
                dec_c.rd_data_sel = 2'b10;
            end
            OPC_JALR: begin
                dec_c.imm         = imm_i_c;
                dec_c.rd_data_sel = 2'b10;
            end
            OPC_BRANCH: begin
                dec_c.rs2_sel = instr_in[24:20];
                dec_c.rd_sel  = '0;
                dec_c.imm     = imm_b_c;
            end
            OPC_LOAD: begin
                dec_c.imm         = imm_i_c;
                dec_c.rd_data_sel = 2'b01;
            end
            OPC_STORE: begin
                dec_c.rs2_sel = instr_in[24:20];
                dec_c.rd_sel  = '0;
                dec_c.imm     = imm_s_c;
            end
            OPC_OP_IMM: begin
                dec_c.imm = imm_i_c;
                b30_c     = (f3_c == 3'b001 || f3_c == 3'b101) ? instr_in[30] : 1'b0;
            end
            OPC_OP: begin
                dec_c.rs2_sel = instr_in[24:20];
                b30_c         = instr_in[30];
                b25_c         = instr_in[25];
            end
            OPC_MISC_MEM: dec_c.imm = imm_i_c;
            OPC_SYSTEM:   dec_c.imm = {20'b0, instr_in[31:20]};
            default: begin
                dec_c.illegal = 1'b1;
                dec_c.rd_sel  = '0;
                dec_c.rs1_sel = '0;
            end
        endcase
        dec_c.full_op_code = {4'b0, b30_c, b25_c, (dec_c.illegal ? 3'b0 : f3_c), opc_c};
    end

    // Pipeline register: load on accept, drop valid on consume or flush, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            instr     <= '0;
            pc_out    <= RESET_PC;
            bus_q     <= '0;
        end else if (accept_c) begin
            out_valid <= 1'b1;
            instr     <= instr_in;
            pc_out    <= pc_in;
            bus_q     <= dec_c;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign full_op_code = bus_q.full_op_code;
    assign rd_data_sel  = bus_q.rd_data_sel;
    assign rs1_sel      = bus_q.rs1_sel;
    assign rs2_sel      = bus_q.rs2_sel;
    assign rd_sel       = bus_q.rd_sel;
    assign imm          = bus_q.imm;
    assign illegal      = bus_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed RV32I words against a behavioural decode model,
// with per-cycle comparison plus literal expectations from hand decoding.
module tb_decode_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [15:0] full_op_code;
    logic [1:0]  rd_data_sel;
    logic [4:0]  rs1_sel;
    logic [4:0]  rs2_sel;
    logic [4:0]  rd_sel;
    logic [31:0] imm;
    logic        illegal;

    decode_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .instr(instr), .pc_out(pc_out),
        .full_op_code(full_op_code), .rd_data_sel(rd_data_sel), .rs1_sel(rs1_sel),
        .rs2_sel(rs2_sel), .rd_sel(rd_sel), .imm(imm), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [15:0] fop;
        logic [1:0]  rds;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    int          n_pass;
    int          n_total;
    logic        chk_en;
    logic [31:0] pc_ctr;
    exp_t        m;

    // Interpret v as a two's-complement number of the given bit width.
    function automatic logic [31:0] sx(int v, int bits);
        int r;
        r = v;
        if (v >= (1 << (bits - 1))) r = v - (1 << bits);
        return 32'(r);
    endfunction

    function automatic exp_t reset_val();
        exp_t e;
        e.valid = 1'b0; e.instr = '0; e.pc = RPC; e.fop = '0; e.rds = '0;
        e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.imm = '0; e.ill = 1'b0;
        return e;
    endfunction

    function automatic exp_t model(logic [31:0] w, logic [31:0] pc);
        exp_t e;
        logic lui, auipc, jal, jalr, br, ld, st, opi, op, misc, sys, b30, b25;
        int   f3;
        lui = (w[6:0] == 7'h37); auipc = (w[6:0] == 7'h17); jal  = (w[6:0] == 7'h6F);
        jalr = (w[6:0] == 7'h67); br   = (w[6:0] == 7'h63); ld   = (w[6:0] == 7'h03);
        st  = (w[6:0] == 7'h23); opi   = (w[6:0] == 7'h13); op   = (w[6:0] == 7'h33);
        misc = (w[6:0] == 7'h0F); sys  = (w[6:0] == 7'h73);
        f3 = int'(w[14:12]);
        e = reset_val();
        e.valid = 1'b1;
        e.instr = w;
        e.pc    = pc;
        if (!(lui || auipc || jal || jalr || br || ld || st || opi || op || misc || sys)) begin
            e.ill = 1'b1;
            e.fop = {9'b0, w[6:0]};
            return e;
        end
        b30   = (op || (opi && (f3 == 1 || f3 == 5))) ? w[30] : 1'b0;
        b25   = op ? w[25] : 1'b0;
        e.fop = {4'b0, b30, b25, w[14:12], w[6:0]};
        e.rs1 = (lui || auipc || jal) ? 5'd0 : w[19:15];
        e.rs2 = (op || st || br) ? w[24:20] : 5'd0;
        e.rd  = (st || br) ? 5'd0 : w[11:7];
        if (jalr || ld || opi || misc) e.imm = sx(int'(w[31:20]), 12);
        else if (st)  e.imm = sx(int'(w[31:25]) * 32 + int'(w[11:7]), 12);
        else if (br)  e.imm = sx(int'(w[31]) * 4096 + int'(w[7]) * 2048
                                 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13);
        else if (jal) e.imm = sx(int'(w[31]) * 1048576 + int'(w[19:12]) * 4096
                                 + int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21);
        else if (lui || auipc) e.imm = w & 32'hFFFF_F000;
        else if (sys) e.imm = 32'(w[31:20]);
        if (ld) e.rds = 2'd1;
        else if (jal || jalr) e.rds = 2'd2;
        else if (lui) e.rds = 2'd3;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference pipeline register, behaviourally described from the handshake rules.
    always @(posedge clk or posedge rst) begin
        if (rst) m <= reset_val();
        else if (in_valid && !flush && (!m.valid || out_ready)) m <= model(instr_in, pc_in);
        else if (flush || out_ready) m.valid <= 1'b0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(m.valid));
            chk("in_ready", 32'(in_ready), 32'(!rst && !flush && (!m.valid || out_ready)));
            chk("instr", instr, m.instr);
            chk("pc_out", pc_out, m.pc);
            chk("full_op_code", 32'(full_op_code), 32'(m.fop));
            chk("rd_data_sel", 32'(rd_data_sel), 32'(m.rds));
            chk("rs1_sel", 32'(rs1_sel), 32'(m.rs1));
            chk("rs2_sel", 32'(rs2_sel), 32'(m.rs2));
            chk("rd_sel", 32'(rd_sel), 32'(m.rd));
            chk("imm", imm, m.imm);
            chk("illegal", 32'(illegal), 32'(m.ill));
        end
    end

    // Drive one cycle of inputs just after a rising edge, then advance one edge.
    task automatic step(logic v, logic [31:0] w, logic ordy, logic fl);
        in_valid  = v;
        instr_in  = w;
        pc_in     = pc_ctr;
        out_ready = ordy;
        flush     = fl;
        pc_ctr    = pc_ctr + 32'd4;
        @(posedge clk);
        #2;
    endtask

    logic [31:0] sweep [14];

    initial begin
        n_pass = 0; n_total = 0; chk_en = 1'b0; pc_ctr = 32'h0000_1000;
        rst = 1'b1; in_valid = 1'b0; instr_in = '0; pc_in = '0; out_ready = 1'b0; flush = 1'b0;
        sweep = '{32'h008000EF, 32'h000080E7, 32'h00001517, 32'hFFC12283, 32'h4030D093,
                  32'h00309093, 32'h0FF0000F, 32'h30529073, 32'h022081B3, 32'h00209463,
                  32'hFF5FF06F, 32'h00000057, 32'h00000032, 32'h40208133};
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst pc_out", pc_out, RPC);
        chk("rst instr", instr, 32'd0);
        rst = 1'b0;

        step(1'b1, 32'h00500093, 1'b1, 1'b0);
        chk("addi out_valid", 32'(out_valid), 32'd1);
        chk("addi fop", 32'(full_op_code), 32'h0013);
        chk("addi rd", 32'(rd_sel), 32'd1);
        chk("addi rs1", 32'(rs1_sel), 32'd0);
        chk("addi rs2", 32'(rs2_sel), 32'd0);
        chk("addi imm", imm, 32'd5);
        chk("addi rds", 32'(rd_data_sel), 32'd0);
        chk("addi pc", pc_out, 32'h0000_1000);

        step(1'b1, 32'h402081B3, 1'b1, 1'b0);
        chk("sub fop", 32'(full_op_code), 32'h0833);
        chk("sub rs1", 32'(rs1_sel), 32'd1);
        chk("sub rs2", 32'(rs2_sel), 32'd2);
        chk("sub rd", 32'(rd_sel), 32'd3);
        chk("sub imm", imm, 32'd0);

        step(1'b1, 32'h0020A423, 1'b1, 1'b0);
        chk("sw fop", 32'(full_op_code), 32'h0123);
        chk("sw imm", imm, 32'd8);
        chk("sw rd", 32'(rd_sel), 32'd0);

        step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
        chk("beq imm", imm, 32'hFFFF_FFFC);

        step(1'b1, 32'h123452B7, 1'b1, 1'b0);
        chk("lui imm", imm, 32'h1234_5000);
        chk("lui rd", 32'(rd_sel), 32'd5);
        chk("lui rds", 32'(rd_data_sel), 32'd3);

        for (int i = 0; i < 5; i++) step(1'b1, 32'h00000013 + 32'(i) * 32'h0010_0000, 1'b0, 1'b0);
        chk("stall instr", instr, 32'h123452B7);
        chk("stall in_ready", 32'(in_ready), 32'd0);
        chk("stall out_valid", 32'(out_valid), 32'd1);
        step(1'b1, 32'h00A00113, 1'b1, 1'b0);
        chk("release instr", instr, 32'h00A00113);

        step(1'b1, 32'h00100193, 1'b1, 1'b1);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush instr kept", instr, 32'h00A00113);

        step(1'b1, 32'h0000007F, 1'b0, 1'b0);
        chk("ill flag", 32'(illegal), 32'd1);
        chk("ill out_valid", 32'(out_valid), 32'd1);
        chk("ill fop", 32'(full_op_code), 32'h007F);
        chk("ill sels", {17'b0, rs1_sel, rs2_sel, rd_sel}, 32'd0);
        chk("ill imm", imm, 32'd0);

        step(1'b1, 32'h00000013, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst in_ready", 32'(in_ready), 32'd0);
        chk("arst instr", instr, 32'd0);
        chk("arst pc_out", pc_out, RPC);
        chk("arst illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        foreach (sweep[i]) begin
            step(1'b1, sweep[i], 1'(i % 3 != 2), 1'b0);
            if (i == 0) chk("jal imm", imm, 32'd8);
            if (i == 4) chk("srai fop", 32'(full_op_code), 32'h0A93);
            if (i == 7) chk("csr imm", imm, 32'h0000_0305);
            if (i % 4 == 3) step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I instruction decode stage that sits between instruction fetch and execute. It accepts a fetched word and PC over a valid/ready handshake. It splits the word into the decode bus consumed by execute and the simulation instruction-table monitor: `instr`, `full_op_code`, `rd_data_sel`, `rs1_sel`, `rs2_sel`, `rd_sel` and `imm`. It holds that bus stable while execute stalls, and drops it on a pipeline flush.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, value driven on `pc_out` while in reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  fetch presents `instr_in` and `pc_in`.
- `in_ready`  out  1  stage can accept this cycle.
- `instr_in`  in  32  fetched instruction word.
- `pc_in`  in  32  PC of `instr_in`.
- `flush`  in  1  kill held and incoming instruction (taken branch/jump).
- `out_valid`  out  1  decode bus holds a live instruction.
- `out_ready`  in  1  execute consumes this cycle.
- `instr`  out  32  registered instruction word.
- `pc_out`  out  32  registered PC.
- `full_op_code`  out  16  {4'b0, b30, b25, instr[14:12], instr[6:0]}.
- `rd_data_sel`  out  2  writeback source: 00 ALU, 01 load data, 10 PC+4, 11 imm.
- `rs1_sel`, `rs2_sel`, `rd_sel`  out  5 each  register indices.
- `imm`  out  32  decoded immediate.
- `illegal`  out  1  instruction is not legal RV32I.

## Operation
- Single-entry pipeline register. `in_ready = !rst && !flush && (!out_valid || out_ready)`.
- Accept occurs when `in_valid && in_ready`. On accept, all outputs load from the combinational decode of `instr_in`/`pc_in`, and `out_valid` is set to 1.
- If `out_valid && out_ready` and no accept occurs, `out_valid` clears. The data outputs keep their last values.
- While `out_valid && !out_ready`, every output is held bit-stable.
- `flush` clears `out_valid` next edge. An input offered in the same cycle is not accepted. Data outputs are not cleared.
- Legal opcodes (instr[1:0] must be 11):
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - BRANCH 1100011, LOAD 0000011, STORE 0100011.
  - OP-IMM 0010011, OP 0110011, MISC-MEM 0001111, SYSTEM 1110011.
- Any other opcode sets `illegal=1`. In that case the sel fields, `imm` and `full_op_code[15:7]` are forced to 0, while `instr` and `pc_out` still load.
- `full_op_code` bit b30 = instr[30], only for OP, or OP-IMM with funct3 001/101; else 0.
- `full_op_code` bit b25 = instr[25], only for OP; else 0.
- `rs1_sel` = instr[19:15] for R/I/S/B formats; 0 for LUI, AUIPC, JAL.
- `rs2_sel` = instr[24:20] for OP, STORE, BRANCH; else 0.
- `rd_sel` = instr[11:7] for all formats except STORE and BRANCH, which drive 0.
- Immediate forms (all sign-extended to 32 bits unless noted):
  - I: instr[31:20], for JALR, LOAD, OP-IMM, MISC-MEM.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, for LUI and AUIPC.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - SYSTEM: zero-extended instr[31:20] (CSR address). OP: 0.
- `rd_data_sel`:
  - 01 for LOAD.
  - 10 for JAL/JALR.
  - 11 for LUI.
  - 00 for everything else, including STORE, BRANCH and illegal.

## Timing
- Reset (asynchronous, immediate):
  - `out_valid`=0, `illegal`=0, `in_ready`=0.
  - `instr`=0, `full_op_code`=0, `rd_data_sel`=0, all sel fields=0, `imm`=0.
  - `pc_out`=`RESET_PC`.
- Reset asserted mid-operation discards the held instruction without waiting for a clock edge.
- Latency: an instruction accepted at edge N is visible with `out_valid=1` immediately after edge N.
- Throughput is one instruction per cycle when `out_ready` stays high. Accept and consume in the same cycle replace the entry without a bubble.
- `in_ready` is combinational from `out_valid`, `out_ready`, `flush` and `rst`. No output is combinational from `instr_in`.
- Simultaneous flush, out_ready and in_valid: flush wins, so nothing is accepted and `out_valid` is 0 next cycle.

## Test plan
- After reset, offer 0x00500093 (ADDI x1,x0,5) with `out_ready`=1:
  - Next cycle: `out_valid`=1, `full_op_code`=0x0013, `rd_sel`=1, `rs1_sel`=0, `rs2_sel`=0, `imm`=5, `rd_data_sel`=00.
- 0x402081B3 (SUB x3,x1,x2): `full_op_code`=0x0833, `rs1_sel`=1, `rs2_sel`=2, `rd_sel`=3, `imm`=0.
- 0x0020A423 (SW x2,8(x1)): `full_op_code`=0x0123, `imm`=8, `rd_sel`=0.
- 0xFE000EE3 (BEQ, offset -4): `imm`=0xFFFFFFFC.
- 0x123452B7 (LUI x5): `imm`=0x12345000, `rd_sel`=5, `rd_data_sel`=11.
- Stall: hold `out_ready`=0 for 5 cycles with `in_valid`=1 and changing `instr_in`.
  - Outputs stay bit-stable and `in_ready`=0 throughout.
  - Release `out_ready`: the next word loads one cycle later.
- Flush: pulse `flush` with `out_valid`=1 and `in_valid`=1.
  - `out_valid`=0 next cycle; the offered word is not accepted.
- Illegal word 0x0000007F: `illegal`=1, `out_valid`=1, sel fields and `imm` = 0.
- Assert `rst` asynchronously mid-stall: all outputs go to their reset values before the next edge.
